mlp_sequencer: RTL

- Control FSM that drives the MLP wrapper's `curr_layer`, `ld_en` and `inc_addr` inputs.
- After a `start` pulse it walks every test case in turn: hidden layer one neuron at a time, output-layer settle, one score cycle, then address increment.
- It tracks case and neuron indices and raises `done` after the last test case.
- It sits beside the wrapper in the top level; its outputs wire directly to the wrapper's inputs of the same name.

---
 rtl/mlp_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mlp_sequencer.sv
// Sequencer for the MLP wrapper: walks every test case through hidden, output
// and score phases, issuing one-hot hidden load strobes and address increments.
module mlp_sequencer #(
  parameter int size_of_hidden_layer       = 30,
  parameter int clog2_size_of_hidden_layer = 5,
  parameter int number_of_test_cases       = 750,
  parameter int clog2_number_of_test_cases = 10,
  parameter int hidden_settle              = 2,
  parameter int output_latency             = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  hold,
  output logic [1:0]                            curr_layer,
  output logic [size_of_hidden_layer-1:0]       ld_en,
  output logic                                  inc_addr,
  output logic                                  busy,
  output logic                                  done,
  output logic [clog2_number_of_test_cases-1:0] case_idx,
  output logic [clog2_size_of_hidden_layer-1:0] neuron_idx
);

  // state  | meaning
  // idle   | waiting for start
  // hidden | hidden layer, one neuron per hidden_settle cycles
  // output | output layer settling for output_latency cycles
  // score  | single scoring cycle
  // next   | address increment, then next case or done
  // done   | run complete, sticky until rst
  typedef enum logic [2:0] {
    st_idle, st_hidden, st_output, st_score, st_next, st_done
  } state_t;

  localparam int nw      = clog2_size_of_hidden_layer;
  localparam int cw      = clog2_number_of_test_cases;
  localparam int cnt_max = (hidden_settle > output_latency) ? hidden_settle : output_latency;
  localparam int cnt_w   = (cnt_max > 1) ? $clog2(cnt_max) : 1;

  localparam logic [cnt_w-1:0] settle_last = cnt_w'(hidden_settle - 1);
  localparam logic [cnt_w-1:0] output_last = cnt_w'(output_latency - 1);
  localparam logic [nw-1:0]    neuron_last = nw'(size_of_hidden_layer - 1);
  localparam logic [cw-1:0]    case_last   = cw'(number_of_test_cases - 1);

  state_t                          state, state_n;
  logic [cnt_w-1:0]                cnt, cnt_n;
  logic [nw-1:0]                   neuron_n;
  logic [cw-1:0]                   case_n;
  logic [1:0]                      layer_n;
  logic [size_of_hidden_layer-1:0] ld_n;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    neuron_n = neuron_idx;
    case_n   = case_idx;
    if (!hold) begin
      case (state)
        st_idle: begin
          if (start) begin
            state_n  = st_hidden;
            cnt_n    = '0;
            neuron_n = '0;
          end
        end
        st_hidden: begin
          if (cnt == settle_last) begin
            cnt_n = '0;
            if (neuron_idx == neuron_last) begin
              neuron_n = '0;
              state_n  = st_output;
            end else begin
              neuron_n = neuron_idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        st_output: begin
          if (cnt == output_last) begin
            cnt_n   = '0;
            state_n = st_score;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        st_score: state_n = st_next;
        st_next: begin
          if (case_idx == case_last) begin
            state_n = st_done;
          end else begin
            case_n  = case_idx + 1'b1;
            state_n = st_hidden;
          end
        end
        st_done: state_n = st_done;
        default: state_n = st_idle;
      endcase
    end
  end

  // Outputs are decoded from the upcoming state so they are registered yet aligned with it.
  always_comb begin
    ld_n = '0;
    if (state_n == st_hidden && cnt_n == settle_last) ld_n[neuron_n] = 1'b1;
    case (state_n)
      st_hidden: layer_n = 2'd1;
      st_output: layer_n = 2'd2;
      st_score:  layer_n = 2'd3;
      default:   layer_n = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= st_idle;
      cnt        <= '0;
      neuron_idx <= '0;
      case_idx   <= '0;
      curr_layer <= 2'd0;
      ld_en      <= '0;
      inc_addr   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      neuron_idx <= neuron_n;
      case_idx   <= case_n;
      curr_layer <= layer_n;
      // Strobes are suppressed while frozen; the pending one fires once hold drops.
      ld_en      <= hold ? '0 : ld_n;
      inc_addr   <= !hold && (state_n == st_next);
      busy       <= (state_n != st_idle) && (state_n != st_done);
      done       <= (state_n == st_done);
    end
  end

endmodule
